reg_array_2d: RTL and testbench

REG_ARRAY_2D -- requirements
Module: reg_array_2d

---
 rtl/reg_array_2d_pkg.sv | 24 ++
 rtl/reg_array_row.sv | 41 ++++
 rtl/reg_array_2d.sv | 119 +++++++++++
 tb/tb_reg_array_2d.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_array_2d_pkg.sv
// Shared types and helpers for the 2-D register array.
// State encoding plus flat-bus offset arithmetic.
package reg_array_2d_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    function automatic int aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int flat_off(
        input int r,
        input int c,
        input int cols,
        input int width
    );
        return (r * cols + c) * width;
    endfunction

endpackage

// File: rtl/reg_array_row.sv
// One row of cells with single-cell load and shift/rotate by one column.
// Shift has precedence over load inside the row.
module reg_array_row
    import reg_array_2d_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int COLS  = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_en,
    input  logic [aw(COLS)-1:0]   load_col,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  shift_en,
    input  logic                  rotate,
    output logic [COLS*WIDTH-1:0] row_flat
);

    logic [WIDTH-1:0] cells [COLS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int c = 0; c < COLS; c++) begin
                cells[c] <= '0;
            end
        end else if (shift_en) begin
            // With COLS=1 the wrap source is the cell itself.
            cells[0] <= rotate ? cells[COLS-1] : '0;
            for (int c = 1; c < COLS; c++) begin
                cells[c] <= cells[c-1];
            end
        end else if (load_en) begin
            cells[load_col] <= load_data;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_out
        assign row_flat[flat_off(0, c, COLS, WIDTH) +: WIDTH] = cells[c];
    end

endmodule

// File: rtl/reg_array_2d.sv
// ROWS x COLS register array with cell writes, row shifts and auto-fill.
// The FSM, fill counter and write decode live here; storage is per row.
module reg_array_2d
    import reg_array_2d_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROWS  = 2,
    parameter int COLS  = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WR_EN,
    input  logic [aw(ROWS)-1:0]        WR_ROW,
    input  logic [aw(COLS)-1:0]        WR_COL,
    input  logic [WIDTH-1:0]           WR_DATA,
    input  logic                       SHIFT_EN,
    input  logic                       ROTATE,
    input  logic                       FILL_START,
    input  logic [WIDTH-1:0]           FILL_BASE,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [ROWS*COLS*WIDTH-1:0] OUT_FLAT
);

    localparam int RW = aw(ROWS);
    localparam int CW = aw(COLS);
    localparam int N  = ROWS * COLS;
    localparam int IW = aw(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] base;
    logic             idle;
    logic             filling;
    logic             fill_go;
    logic             shift_go;
    logic             wr_go;
    logic [RW-1:0]    fill_row;
    logic [CW-1:0]    fill_col;
    logic [CW-1:0]    ld_col;
    logic [WIDTH-1:0] ld_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= reg_array_2d_pkg::IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            reg_array_2d_pkg::IDLE:
                if (FILL_START) state_nx = reg_array_2d_pkg::FILL;
            reg_array_2d_pkg::FILL:
                if (idx == LAST) state_nx = reg_array_2d_pkg::DONE;
            reg_array_2d_pkg::DONE:
                state_nx = reg_array_2d_pkg::IDLE;
            default:
                state_nx = reg_array_2d_pkg::IDLE;
        endcase
    end

    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        if (state == reg_array_2d_pkg::FILL) BUSY = 1'b1;
        if (state == reg_array_2d_pkg::DONE) DONE = 1'b1;
    end

    // Requests are only honoured in IDLE, highest priority first.
    assign idle     = (state == reg_array_2d_pkg::IDLE);
    assign filling  = (state == reg_array_2d_pkg::FILL);
    assign fill_go  = idle && FILL_START;
    assign shift_go = idle && !FILL_START && SHIFT_EN;
    assign wr_go    = idle && !FILL_START && !SHIFT_EN && WR_EN
                      && (int'(WR_ROW) < ROWS) && (int'(WR_COL) < COLS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx  <= '0;
            base <= '0;
        end else if (fill_go) begin
            idx  <= '0;
            base <= FILL_BASE;
        end else if (filling) begin
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    assign fill_row = RW'(int'(idx) / COLS);
    assign fill_col = CW'(int'(idx) % COLS);
    assign ld_col   = filling ? fill_col : WR_COL;
    assign ld_data  = filling ? base + WIDTH'(idx) : WR_DATA;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic ld;
        assign ld = filling ? (fill_row == RW'(r))
                            : (wr_go && WR_ROW == RW'(r));

        reg_array_row #(
            .WIDTH (WIDTH),
            .COLS  (COLS)
        ) u_row (
            .CLK       (CLK),
            .RST       (RST),
            .load_en   (ld),
            .load_col  (ld_col),
            .load_data (ld_data),
            .shift_en  (shift_go),
            .rotate    (ROTATE),
            .row_flat  (OUT_FLAT[flat_off(r, 0, COLS, WIDTH) +: COLS*WIDTH])
        );
    end

endmodule

// File: tb/tb_reg_array_2d.sv
// Scoreboard bench for reg_array_2d (WIDTH=8, ROWS=2, COLS=6).
// Driver pushes model predictions; monitor pops and compares each cycle.
module tb_reg_array_2d;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WR_EN = 1'b0;
    logic [0:0]  WR_ROW = '0;
    logic [2:0]  WR_COL = '0;
    logic [7:0]  WR_DATA = '0;
    logic        SHIFT_EN = 1'b0;
    logic        ROTATE = 1'b0;
    logic        FILL_START = 1'b0;
    logic [7:0]  FILL_BASE = '0;
    logic        BUSY;
    logic        DONE;
    logic [95:0] OUT_FLAT;

    reg_array_2d #(.WIDTH(8), .ROWS(2), .COLS(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WR_EN      (WR_EN),
        .WR_ROW     (WR_ROW),
        .WR_COL     (WR_COL),
        .WR_DATA    (WR_DATA),
        .SHIFT_EN   (SHIFT_EN),
        .ROTATE     (ROTATE),
        .FILL_START (FILL_START),
        .FILL_BASE  (FILL_BASE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OUT_FLAT   (OUT_FLAT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [95:0] flat;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference: plain 2-D array, fill position (-1 = none), done flag.
    logic [7:0] m [2][6];
    int         fpos = -1;
    bit         mdone = 0;
    logic [7:0] mbase = '0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [95:0] model_flat();
        logic [95:0] f;
        f = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 6; c++)
                f[(r*6+c)*8 +: 8] = m[r][c];
        return f;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 6; c++)
                m[r][c] = '0;
        fpos  = -1;
        mdone = 0;
    endtask

    task automatic model_edge(input bit fs, input logic [7:0] fb,
                              input bit sh, input bit rot, input bit we,
                              input int wr, input int wc,
                              input logic [7:0] wd);
        logic [7:0] t;
        if (fpos >= 0) begin
            m[fpos/6][fpos%6] = mbase + 8'(fpos);
            fpos++;
            if (fpos == 12) begin
                fpos  = -1;
                mdone = 1;
            end
        end else if (mdone) begin
            mdone = 0;
        end else if (fs) begin
            mbase = fb;
            fpos  = 0;
        end else if (sh) begin
            for (int r = 0; r < 2; r++) begin
                t = m[r][5];
                for (int c = 5; c > 0; c--) m[r][c] = m[r][c-1];
                m[r][0] = rot ? t : 8'h00;
            end
        end else if (we && wr < 2 && wc < 6) begin
            m[wr][wc] = wd;
        end
    endtask

    task automatic step(input bit fs, input logic [7:0] fb, input bit sh,
                        input bit rot, input bit we, input int wr,
                        input int wc, input logic [7:0] wd);
        exp_t e;
        @(negedge CLK);
        FILL_START = fs;
        FILL_BASE  = fb;
        SHIFT_EN   = sh;
        ROTATE     = rot;
        WR_EN      = we;
        WR_ROW     = 1'(wr);
        WR_COL     = 3'(wc);
        WR_DATA    = wd;
        model_edge(fs, fb, sh, rot, we, wr, wc, wd);
        e.flat = model_flat();
        e.busy = (fpos >= 0);
        e.done = mdone;
        q.push_back(e);
    endtask

    task automatic idle_step();
        step(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic settle();
        @(posedge CLK);
        #2;
    endtask

    // Monitor: one prediction per clock edge after reset release.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cycle", {30'd0, OUT_FLAT, BUSY, DONE},
                    {30'd0, e.flat, e.busy, e.done});
            end
        end
    end

    initial begin
        int         busy_n;
        int         done_n;
        logic [7:0] row0 [6];
        logic [7:0] rexp [6];

        model_reset();
        #12;
        chk("reset_state", {31'd0, OUT_FLAT, BUSY, DONE}, '0);
        @(negedge CLK);
        RST = 1'b0;

        step(0, 8'h00, 0, 0, 1, 1, 3, 8'hA5);
        settle();
        chk("wr_1_3", {120'd0, OUT_FLAT[79:72]}, 128'hA5);
        chk("wr_others", {32'd0, OUT_FLAT & ~(96'hFF << 72)}, '0);

        step(1, 8'hFC, 0, 0, 0, 0, 0, 8'h00);
        settle();
        busy_n = int'(BUSY);
        done_n = int'(DONE);
        for (int i = 0; i < 13; i++) begin
            idle_step();
            settle();
            busy_n += int'(BUSY);
            done_n += int'(DONE);
        end
        chk("fill_busy_cycles", 128'(busy_n), 128'd12);
        chk("fill_done_pulses", 128'(done_n), 128'd1);
        for (int i = 0; i < 12; i++)
            chk("fill_cell", {120'd0, OUT_FLAT[i*8 +: 8]},
                {120'd0, 8'(252 + i)});

        rexp = '{8'h01, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00};
        step(0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        settle();
        for (int c = 0; c < 6; c++) row0[c] = OUT_FLAT[c*8 +: 8];
        for (int c = 0; c < 6; c++)
            chk("rotate_row0", {120'd0, row0[c]}, {120'd0, rexp[c]});

        rexp = '{8'h00, 8'h01, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
        step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        settle();
        for (int c = 0; c < 6; c++)
            chk("zfill_row0", {120'd0, OUT_FLAT[c*8 +: 8]},
                {120'd0, rexp[c]});

        step(1, 8'h30, 1, 1, 1, 0, 2, 8'h77);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 1, 0, 0, 8'h55);
        for (int i = 0; i < 10; i++) idle_step();
        settle();
        for (int i = 0; i < 12; i++)
            chk("prio_fill_cell", {120'd0, OUT_FLAT[i*8 +: 8]},
                {120'd0, 8'(8'h30 + i)});

        step(0, 8'h00, 0, 0, 1, 1, 7, 8'hEE);
        step(0, 8'h00, 0, 0, 1, 0, 6, 8'hEE);
        step(0, 8'h00, 0, 0, 1, 0, 5, 8'h99);

        step(1, 8'hE0, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) idle_step();
        settle();
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid_fill", {31'd0, OUT_FLAT, BUSY, DONE}, '0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        done_n = 0;
        step(0, 8'h00, 0, 0, 1, 0, 6, 8'h5A);
        settle();
        chk("oob_write", {32'd0, OUT_FLAT}, '0);
        for (int i = 0; i < 14; i++) begin
            idle_step();
            settle();
            done_n += int'(DONE);
        end
        chk("no_done_after_rst", 128'(done_n), 128'd0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, 8'($urandom),
                 $urandom_range(0, 3) == 0, 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), 8'($urandom));
        end
        settle();
        settle();
        chk("queue_drained", 128'(q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
